// File: rtl/mem_bus_arbiter.sv
// Two-port (IF / MEM) arbiter for the single pulse-request / pulse-response core memory bus.
// MEM has priority; a starvation counter forces an IF grant after STARVE_LIMIT MEM wins.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_request_enable,
  input  logic        if_mode,
  input  logic [31:0] if_addr,
  input  logic [31:0] if_wdata,
  input  logic [3:0]  if_wstrb,
  output logic        if_response_enable,
  output logic [31:0] if_data,
  input  logic        mem_request_enable,
  input  logic        mem_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mem_data,
  output logic        bus_request_enable,
  output logic        bus_mode,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_response_enable,
  input  logic [31:0] bus_data,
  output logic        busy,
  output logic        owner,
  output logic        protocol_error
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  typedef struct packed {
    logic          mode;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
  } req_t;

  state_t        state_q, state_d;
  logic          if_pend_q, if_pend_d, mem_pend_q, mem_pend_d;
  req_t          if_slot_q, if_slot_d, mem_slot_q, mem_slot_d;
  req_t          bus_slot_q, bus_slot_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          owner_q, owner_d, busy_q, busy_d, perr_q, perr_d;
  logic          bus_req_q, bus_req_d;
  logic          if_resp_q, if_resp_d, mem_resp_q, mem_resp_d;
  logic [DW-1:0] if_data_q, if_data_d, mem_data_q, mem_data_d;

  req_t if_in, mem_in, if_cur, mem_cur;
  logic done, if_out, mem_out, if_bad, mem_bad, if_acc, mem_acc;
  logic if_elig, mem_elig, can_grant, grant_if, grant_mem;

  assign if_in  = req_t'({if_mode, if_addr, if_wdata, if_wstrb});
  assign mem_in = req_t'({mem_mode, mem_addr, mem_wdata, mem_wstrb});

  // A port stops counting as outstanding at the edge its response is sampled.
  assign done    = (state_q != ST_IDLE) && bus_response_enable;
  assign if_out  = (state_q != ST_IDLE) && !owner_q && !bus_response_enable;
  assign mem_out = (state_q != ST_IDLE) && owner_q && !bus_response_enable;

  assign if_bad  = if_request_enable && (if_pend_q || if_out);
  assign mem_bad = mem_request_enable && (mem_pend_q || mem_out);
  assign if_acc  = if_request_enable && !if_bad;
  assign mem_acc = mem_request_enable && !mem_bad;

  assign if_elig  = if_pend_q || if_acc;
  assign mem_elig = mem_pend_q || mem_acc;
  assign if_cur   = if_pend_q ? if_slot_q : if_in;
  assign mem_cur  = mem_pend_q ? mem_slot_q : mem_in;

  assign can_grant = (state_q == ST_IDLE) || done;
  assign grant_if  = can_grant && if_elig && (!mem_elig || (starve_q == CW'(STARVE_LIMIT)));
  assign grant_mem = can_grant && mem_elig && !grant_if;

  // Next-state, slot, arbitration and response routing.
  always_comb begin
    state_d    = state_q;
    if_pend_d  = if_pend_q;
    mem_pend_d = mem_pend_q;
    if_slot_d  = if_slot_q;
    mem_slot_d = mem_slot_q;
    bus_slot_d = bus_slot_q;
    starve_d   = starve_q;
    owner_d    = owner_q;
    perr_d     = perr_q | if_bad | mem_bad;
    bus_req_d  = 1'b0;
    if_resp_d  = 1'b0;
    mem_resp_d = 1'b0;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;

    case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d = ST_IDLE;
      if (owner_q) begin
        mem_resp_d = 1'b1;
        mem_data_d = bus_data;
      end else begin
        if_resp_d = 1'b1;
        if_data_d = bus_data;
      end
    end

    if (if_acc) begin
      if_pend_d = 1'b1;
      if_slot_d = if_in;
    end
    if (mem_acc) begin
      mem_pend_d = 1'b1;
      mem_slot_d = mem_in;
    end

    if (grant_if) begin
      state_d    = ST_ISSUE;
      bus_req_d  = 1'b1;
      owner_d    = 1'b0;
      bus_slot_d = if_cur;
      if_pend_d  = 1'b0;
    end else if (grant_mem) begin
      state_d    = ST_ISSUE;
      bus_req_d  = 1'b1;
      owner_d    = 1'b1;
      bus_slot_d = mem_cur;
      mem_pend_d = 1'b0;
    end

    if (grant_if || !if_elig) begin
      starve_d = '0;
    end else if (grant_mem) begin
      starve_d = starve_q + CW'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      if_pend_q  <= 1'b0;
      mem_pend_q <= 1'b0;
      if_slot_q  <= '0;
      mem_slot_q <= '0;
      bus_slot_q <= '0;
      starve_q   <= '0;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      if_resp_q  <= 1'b0;
      mem_resp_q <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      if_pend_q  <= if_pend_d;
      mem_pend_q <= mem_pend_d;
      if_slot_q  <= if_slot_d;
      mem_slot_q <= mem_slot_d;
      bus_slot_q <= bus_slot_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      bus_req_q  <= bus_req_d;
      if_resp_q  <= if_resp_d;
      mem_resp_q <= mem_resp_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign bus_request_enable  = bus_req_q;
  assign bus_mode            = bus_slot_q.mode;
  assign bus_addr            = bus_slot_q.addr;
  assign bus_wdata           = bus_slot_q.wdata;
  assign bus_wstrb           = bus_slot_q.wstrb;
  assign if_response_enable  = if_resp_q;
  assign if_data             = if_data_q;
  assign mem_response_enable = mem_resp_q;
  assign mem_data            = mem_data_q;
  assign busy                = busy_q;
  assign owner               = owner_q;
  assign protocol_error      = perr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single transfers, priority, starvation, protocol errors,
// reset mid-transaction and a zero-wait downstream bus.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_request_enable, if_mode, mem_request_enable, mem_mode;
  logic [31:0] if_addr, if_wdata, mem_addr, mem_wdata;
  logic [3:0]  if_wstrb, mem_wstrb;
  logic        if_response_enable, mem_response_enable;
  logic [31:0] if_data, mem_data;
  logic        bus_request_enable, bus_mode;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_response_enable;
  logic [31:0] bus_data;
  logic        busy, owner, protocol_error;

  logic        zw;
  logic        rsp_drv;
  logic [31:0] data_drv;

  int vecs = 0;
  int miscmp = 0;
  int if_rsp_cnt = 0;
  int mem_rsp_cnt = 0;
  int breq_cnt = 0;

  localparam logic [31:0] ZW_MASK = 32'hA5A5_0000;

  // Downstream model: driven responses, or a zero-wait echo of the request pulse.
  assign bus_response_enable = zw ? bus_request_enable : rsp_drv;
  assign bus_data            = zw ? (bus_addr ^ ZW_MASK) : data_drv;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_request_enable(if_request_enable), .if_mode(if_mode), .if_addr(if_addr),
    .if_wdata(if_wdata), .if_wstrb(if_wstrb),
    .if_response_enable(if_response_enable), .if_data(if_data),
    .mem_request_enable(mem_request_enable), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_response_enable(mem_response_enable), .mem_data(mem_data),
    .bus_request_enable(bus_request_enable), .bus_mode(bus_mode), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_response_enable(bus_response_enable), .bus_data(bus_data),
    .busy(busy), .owner(owner), .protocol_error(protocol_error)
  );

  always @(negedge clk) begin
    if (if_response_enable) if_rsp_cnt++;
    if (mem_response_enable) mem_rsp_cnt++;
    if (bus_request_enable) breq_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_request_enable = 0; if_mode = 0; if_addr = 0; if_wdata = 0; if_wstrb = 0;
    mem_request_enable = 0; mem_mode = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    rsp_drv = 0; data_drv = 0;
  endtask

  task automatic if_req(input logic [31:0] a);
    if_request_enable = 1; if_mode = 0; if_addr = a; if_wdata = 0; if_wstrb = 0;
  endtask

  task automatic mem_req(input logic m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_request_enable = 1; mem_mode = m; mem_addr = a; mem_wdata = d; mem_wstrb = s;
  endtask

  task automatic test_reset();
    logic [141:0] outs;
    zw = 0;
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    outs = {bus_request_enable, bus_mode, bus_addr, bus_wdata, bus_wstrb, busy, owner,
            protocol_error, if_response_enable, if_data, mem_response_enable, mem_data};
    vecs++; if (outs !== '0) begin miscmp++; $display("FAIL reset_outputs got %h exp 0", outs); end
  endtask

  task automatic test_single_read();
    int r0;
    if_req(32'h100);
    tick();
    if_request_enable = 0;
    vecs++; if ({bus_request_enable, bus_mode, bus_addr, busy, owner} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b0}) begin
      miscmp++; $display("FAIL t1_issue got req=%b mode=%b addr=%h busy=%b own=%b exp 1 0 100 1 0",
                         bus_request_enable, bus_mode, bus_addr, busy, owner); end
    tick();
    vecs++; if ({bus_request_enable, busy} !== 2'b01) begin
      miscmp++; $display("FAIL t1_wait got req=%b busy=%b exp 0 1", bus_request_enable, busy); end
    tick();
    r0 = if_rsp_cnt;
    rsp_drv = 1; data_drv = 32'hDEADBEEF;
    tick();
    rsp_drv = 0; data_drv = 0;
    vecs++; if ({if_response_enable, if_data, mem_response_enable, busy} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      miscmp++; $display("FAIL t1_resp got ifr=%b ifd=%h memr=%b busy=%b exp 1 deadbeef 0 0",
                         if_response_enable, if_data, mem_response_enable, busy); end
    tick(); tick();
    vecs++; if (if_rsp_cnt - r0 !== 1) begin
      miscmp++; $display("FAIL t1_resp_count got %0d exp 1", if_rsp_cnt - r0); end
  endtask

  task automatic test_priority();
    int i0, m0;
    i0 = if_rsp_cnt; m0 = mem_rsp_cnt;
    if_req(32'h300);
    mem_req(1'b1, 32'h200, 32'h1234_5678, 4'b1111);
    tick();
    if_request_enable = 0; mem_request_enable = 0;
    vecs++; if ({bus_request_enable, owner, bus_mode, bus_addr, bus_wdata, bus_wstrb} !==
                {1'b1, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'hF}) begin
      miscmp++; $display("FAIL t2_mem_first got req=%b own=%b mode=%b addr=%h wd=%h ws=%h exp 1 1 1 200 12345678 f",
                         bus_request_enable, owner, bus_mode, bus_addr, bus_wdata, bus_wstrb); end
    tick();
    vecs++; if ({bus_mode, bus_addr, bus_wstrb} !== {1'b1, 32'h200, 4'hF}) begin
      miscmp++; $display("FAIL t2_hold got mode=%b addr=%h ws=%h exp 1 200 f", bus_mode, bus_addr, bus_wstrb); end
    rsp_drv = 1; data_drv = 32'h0;
    tick();
    rsp_drv = 0;
    vecs++; if ({mem_response_enable, if_response_enable, bus_request_enable, owner, bus_addr, bus_mode} !==
                {1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0}) begin
      miscmp++; $display("FAIL t2_if_next got memr=%b ifr=%b req=%b own=%b addr=%h mode=%b exp 1 0 1 0 300 0",
                         mem_response_enable, if_response_enable, bus_request_enable, owner, bus_addr, bus_mode); end
    tick();
    rsp_drv = 1; data_drv = 32'hCAFEF00D;
    tick();
    rsp_drv = 0; data_drv = 0;
    vecs++; if ({if_response_enable, if_data, mem_response_enable} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
      miscmp++; $display("FAIL t2_if_resp got ifr=%b ifd=%h memr=%b exp 1 cafef00d 0",
                         if_response_enable, if_data, mem_response_enable); end
    tick(); tick();
    vecs++; if ({if_rsp_cnt - i0, mem_rsp_cnt - m0} !== {32'd1, 32'd1}) begin
      miscmp++; $display("FAIL t2_counts got if=%0d mem=%0d exp 1 1", if_rsp_cnt - i0, mem_rsp_cnt - m0); end
  endtask

  task automatic test_starvation();
    logic [4:0] owners;
    logic [31:0] last_mem;
    if_req(32'h400);
    mem_req(1'b0, 32'h500, 0, 0);
    tick();
    if_request_enable = 0; mem_request_enable = 0;
    owners[0] = owner;
    for (int k = 1; k < 5; k++) begin
      tick();
      rsp_drv = 1; data_drv = 32'h5000 + 32'(k);
      last_mem = 32'h500 + 32'(k * 4);
      mem_req(1'b0, last_mem, 0, 0);
      tick();
      rsp_drv = 0; mem_request_enable = 0;
      owners[k] = owner;
      vecs++; if ({bus_request_enable, mem_response_enable, mem_data} !== {1'b1, 1'b1, 32'h5000 + 32'(k)}) begin
        miscmp++; $display("FAIL t3_grant%0d got req=%b memr=%b memd=%h exp 1 1 %h",
                           k + 1, bus_request_enable, mem_response_enable, mem_data, 32'h5000 + 32'(k)); end
    end
    vecs++; if (owners !== 5'b01111) begin
      miscmp++; $display("FAIL t3_owner_seq got %b exp 01111 (grant1 at lsb)", owners); end
    vecs++; if (bus_addr !== 32'h400) begin
      miscmp++; $display("FAIL t3_if_addr got %h exp 400", bus_addr); end
    tick();
    rsp_drv = 1; data_drv = 32'h4444;
    tick();
    rsp_drv = 0;
    vecs++; if ({if_response_enable, if_data, bus_request_enable, owner, bus_addr} !==
                {1'b1, 32'h4444, 1'b1, 1'b1, last_mem}) begin
      miscmp++; $display("FAIL t3_after_if got ifr=%b ifd=%h req=%b own=%b addr=%h exp 1 4444 1 1 %h",
                         if_response_enable, if_data, bus_request_enable, owner, bus_addr, last_mem); end
    tick();
    rsp_drv = 1; data_drv = 32'h6666;
    tick();
    rsp_drv = 0;
    vecs++; if ({mem_response_enable, mem_data, busy, protocol_error} !== {1'b1, 32'h6666, 1'b0, 1'b0}) begin
      miscmp++; $display("FAIL t3_final got memr=%b memd=%h busy=%b perr=%b exp 1 6666 0 0",
                         mem_response_enable, mem_data, busy, protocol_error); end
    tick();
  endtask

  task automatic test_protocol_error();
    int b0;
    if_req(32'h600);
    tick();
    if_req(32'h700);
    tick();
    if_request_enable = 0;
    vecs++; if (protocol_error !== 1'b1) begin
      miscmp++; $display("FAIL t4_perr_set got %b exp 1", protocol_error); end
    b0 = breq_cnt;
    rsp_drv = 1; data_drv = 32'h7777;
    tick();
    rsp_drv = 0;
    vecs++; if ({if_response_enable, if_data, bus_request_enable} !== {1'b1, 32'h7777, 1'b0}) begin
      miscmp++; $display("FAIL t4_resp got ifr=%b ifd=%h req=%b exp 1 7777 0",
                         if_response_enable, if_data, bus_request_enable); end
    tick(); tick(); tick();
    vecs++; if ({busy, protocol_error, 32'(breq_cnt - b0)} !== {1'b0, 1'b1, 32'd0}) begin
      miscmp++; $display("FAIL t4_sticky got busy=%b perr=%b extra_req=%0d exp 0 1 0",
                         busy, protocol_error, breq_cnt - b0); end
  endtask

  task automatic test_reset_mid();
    int i0;
    test_reset();
    vecs++; if (protocol_error !== 1'b0) begin
      miscmp++; $display("FAIL t5_perr_clear got %b exp 0", protocol_error); end
    if_req(32'h800);
    tick();
    if_request_enable = 0;
    tick();
    i0 = if_rsp_cnt;
    rst = 1;
    tick();
    rst = 0;
    vecs++; if ({busy, bus_request_enable} !== 2'b00) begin
      miscmp++; $display("FAIL t5_after_rst got busy=%b req=%b exp 0 0", busy, bus_request_enable); end
    tick();
    rsp_drv = 1; data_drv = 32'hBAD0BAD0;
    tick();
    rsp_drv = 0;
    tick();
    vecs++; if ({32'(if_rsp_cnt - i0), mem_response_enable, busy} !== {32'd0, 1'b0, 1'b0}) begin
      miscmp++; $display("FAIL t5_late_resp got ifresps=%0d memr=%b busy=%b exp 0 0 0",
                         if_rsp_cnt - i0, mem_response_enable, busy); end
    if_req(32'h900);
    tick();
    if_request_enable = 0;
    tick();
    rsp_drv = 1; data_drv = 32'h0BADF00D;
    tick();
    rsp_drv = 0;
    vecs++; if ({if_response_enable, if_data} !== {1'b1, 32'h0BADF00D}) begin
      miscmp++; $display("FAIL t5_recover got ifr=%b ifd=%h exp 1 0badf00d", if_response_enable, if_data); end
    tick();
  endtask

  task automatic test_zero_wait();
    int b0;
    logic [31:0] a;
    zw = 1;
    b0 = breq_cnt;
    a = 32'hA00;
    if_req(a);
    for (int k = 0; k < 6; k++) begin
      tick();
      if_request_enable = 0; mem_request_enable = 0;
      vecs++; if ({bus_request_enable, owner, bus_addr} !== {1'b1, 1'(k % 2), a}) begin
        miscmp++; $display("FAIL t6_grant%0d got req=%b own=%b addr=%h exp 1 %0d %h",
                           k, bus_request_enable, owner, bus_addr, k % 2, a); end
      tick();
      if (k % 2 == 0) begin
        vecs++; if ({if_response_enable, if_data, mem_response_enable, bus_request_enable} !==
                    {1'b1, a ^ ZW_MASK, 1'b0, 1'b0}) begin
          miscmp++; $display("FAIL t6_if_resp%0d got ifr=%b ifd=%h memr=%b req=%b exp 1 %h 0 0",
                             k, if_response_enable, if_data, mem_response_enable, bus_request_enable, a ^ ZW_MASK); end
      end else begin
        vecs++; if ({mem_response_enable, mem_data, if_response_enable, bus_request_enable} !==
                    {1'b1, a ^ ZW_MASK, 1'b0, 1'b0}) begin
          miscmp++; $display("FAIL t6_mem_resp%0d got memr=%b memd=%h ifr=%b req=%b exp 1 %h 0 0",
                             k, mem_response_enable, mem_data, if_response_enable, bus_request_enable, a ^ ZW_MASK); end
      end
      a = a + 32'h4;
      if (k < 5) begin
        if (k % 2 == 0) mem_req(1'b0, a, 0, 0);
        else if_req(a);
      end
    end
    tick(); tick();
    vecs++; if ({32'(breq_cnt - b0), busy} !== {32'd6, 1'b0}) begin
      miscmp++; $display("FAIL t6_grant_count got %0d busy=%b exp 6 0", breq_cnt - b0, busy); end
    zw = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_starvation();
    test_protocol_error();
    test_reset_mid();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
